codeword_deserializer: RTL and testbench
========================================

Name: codeword_deserializer

Overview:
- Upstream feeder for the 7-bit codeword decoder: assembles serial bits arriving on a user IO pin into parallel WORD_W-bit codewords.
- Buffers assembled words in a small FIFO and presents them with a valid/ready handshake; the decoder's 7-bit input connects to out_word.
- Flags framing and overflow errors for status readback over the management bus.

Parameters:
- WORD_W, 7, bits per codeword; the decoder requires 7.
- FIFO_DEPTH, 2, output FIFO entries; must be a power of two and at least 2.
- CONTINUOUS, 1: after a word completes, 1 = the next bit starts a new word; 0 = return to IDLE and wait for sof.

Ports:
- wb_clk_i  in  1  single clock; all logic is on the rising edge.
- wb_rst_i  in  1  synchronous active-high reset.
- ser_in  in  1  serial data bit, LSB first.
- ser_valid  in  1  ser_in is valid this cycle.
- sof  in  1  start-of-frame; qualified by ser_valid and marks bit 0.
- out_word  out  WORD_W  head-of-FIFO codeword.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_word when out_valid is also high.
- sync_err  out  1  sticky: sof arrived mid-word.
- ovf_err  out  1  sticky: a word completed while the FIFO was full and not popping.
- err_clr  in  1  clears both sticky flags.
- word_cnt  out  8  count of words pushed into the FIFO; wraps at 256.

Behaviour:
- Reset (sync, wb_rst_i=1 at posedge):
  - state=IDLE, bit count=0, shift register=0, FIFO emptied.
  - out_valid=0, out_word=0, sync_err=0, ovf_err=0, word_cnt=0.
  - Reset mid-word or mid-FIFO discards all partial and buffered data.
- State machine IDLE / ASSEMBLE; bit count runs 0..WORD_W-1.
  - IDLE: ser_valid & sof → shift[0]=ser_in, count=1, go to ASSEMBLE. ser_valid without sof is ignored.
  - ASSEMBLE, ser_valid & !sof: shift[count]=ser_in, count++.
  - ASSEMBLE, ser_valid & sof & count≠0: set sync_err, discard the partial word, restart with this bit as bit 0 (count=1).
  - No ser_valid: hold state; gaps of any length are allowed.
- Word completion: the cycle the bit at index WORD_W-1 is accepted.
  - The full word (including that bit) is pushed at this edge.
  - count returns to 0.
  - Next state is ASSEMBLE if CONTINUOUS=1, otherwise IDLE.
- Push condition: FIFO not full, or a pop occurs the same cycle.
  - If full and no pop: drop the word, set ovf_err, leave word_cnt unchanged.
- Latency: out_valid rises the cycle after the completing bit's edge, i.e. on the first edge where the FIFO holds the word.
- Pop: out_valid & out_ready at posedge. out_word shows the new head from the next cycle. Empty FIFO ignores out_ready.
- Simultaneous push and pop:
  - When full: both occur, occupancy unchanged.
  - When empty: push only; the word appears the next cycle (no bypass).
- FIFO order is strict first-in first-out; pointers wrap modulo FIFO_DEPTH.
- out_word holds its value while out_valid=0. No combinational path from out_ready to out_valid.
- Sticky flags:
  - err_clr clears sync_err and ovf_err.
  - A new error in the same cycle as err_clr wins, so the flag stays 1.
- word_cnt increments by 1 per successful push and wraps 255→0.

Test Plan:
- Reset, then sof on first bit, stream 1,0,0,1,1,0,1 on consecutive cycles, out_ready=1 → out_word=7'b1011001 with out_valid high for exactly 1 cycle, starting the cycle after the 7th bit; word_cnt=1.
- out_ready=0; send three words 0x59, 0x2A, 0x7F → FIFO holds 0x59, 0x2A; ovf_err=1; word_cnt=2. Then raise out_ready → pops return 0x59, then 0x2A, and out_valid falls.
- sof, 3 bits 1,1,1, then sof with bits 0,0,0,0,0,0,1 → sync_err=1; out_word=7'b1000000; the partial word is never output.
- CONTINUOUS=0: after one word, feed 7 bits without sof → no output and state remains IDLE. CONTINUOUS=1: the same input yields a second word.
- FIFO full with out_ready=1 while a word completes → word accepted, occupancy stays 2, ovf_err stays 0; then assert err_clr in the same cycle as a new overflow → ovf_err remains 1.
- Assert wb_rst_i after 4 bits with 1 word buffered → next cycle out_valid=0, word_cnt=0, flags=0; a fresh sof plus 7 bits yields the correct word.

Source files
------------

// File: rtl/codeword_deserializer.sv
// Serial-to-parallel codeword assembler with a small output FIFO.
// Feeds the 7-bit decoder; sticky framing/overflow flags for status.
module codeword_deserializer #(
  parameter int WORD_W     = 7,
  parameter int FIFO_DEPTH = 2,
  parameter int CONTINUOUS = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              ser_in,
  input  logic              ser_valid,
  input  logic              sof,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sync_err,
  output logic              ovf_err,
  input  logic              err_clr,
  output logic [7:0]        word_cnt
);

  localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);
  localparam logic [PW:0] FULL_OCC = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    ASSEMBLE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] word_d;
  logic [CW-1:0]     idx;
  logic              accept, start, done, sync_set;

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [PW:0]       occ_q;
  logic [WORD_W-1:0] hold_q;
  logic              sync_q, ovf_q;
  logic [7:0]        cnt_w_q;
  logic              full, pop, push, ovf_set;

  // Bit acceptance, word assembly and framing next-state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    word_d   = shift_q;
    idx      = '0;
    accept   = 1'b0;
    start    = 1'b0;
    done     = 1'b0;
    sync_set = 1'b0;
    if (ser_valid) begin
      unique case (state_q)
        IDLE: begin
          accept = sof;
          start  = sof;
        end
        ASSEMBLE: begin
          accept   = 1'b1;
          start    = sof;
          sync_set = sof && (cnt_q != '0);
        end
      endcase
    end
    if (accept) begin
      idx         = start ? '0 : cnt_q;
      word_d      = start ? '0 : shift_q;
      word_d[idx] = ser_in;
      shift_d     = word_d;
      if (idx == LAST) begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = (CONTINUOUS != 0) ? ASSEMBLE : IDLE;
      end else begin
        cnt_d   = idx + 1'b1;
        state_d = ASSEMBLE;
      end
    end
  end

  assign out_valid = (occ_q != '0);
  assign out_word  = out_valid ? mem_q[rd_q] : hold_q;
  assign full      = (occ_q == FULL_OCC);
  assign pop       = out_valid && out_ready;
  assign push      = done && (!full || pop);
  assign ovf_set   = done && full && !pop;
  assign sync_err  = sync_q;
  assign ovf_err   = ovf_q;
  assign word_cnt  = cnt_w_q;

  // Framing state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // FIFO storage, pointers, sticky flags and push counter
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      hold_q  <= '0;
      sync_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_w_q <= '0;
    end else begin
      hold_q <= out_word;
      sync_q <= (sync_q && !err_clr) || sync_set;
      ovf_q  <= (ovf_q && !err_clr) || ovf_set;
      if (push) begin
        mem_q[wr_q] <= word_d;
        wr_q        <= wr_q + 1'b1;
        cnt_w_q     <= cnt_w_q + 8'd1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_codeword_deserializer.sv
// Bench for codeword_deserializer: directed scenarios plus a
// randomized run against a queue-based behavioural model.
module tb_codeword_deserializer;

  localparam int W = 7;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst, sin, sv, sf, rdy, clr;
  logic [W-1:0] ow, ow0;
  logic ov, se, oe, ov0, se0, oe0;
  logic [7:0] wc, wc0;

  int checks = 0;
  int errors = 0;

  bit m_in;
  bit m_bits[$];
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_last;
  bit m_sync, m_ovf;
  int m_cnt;

  always #5 clk = ~clk;

  codeword_deserializer #(.WORD_W(W), .FIFO_DEPTH(D), .CONTINUOUS(1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .ser_in(sin), .ser_valid(sv),
    .sof(sf), .out_word(ow), .out_valid(ov), .out_ready(rdy),
    .sync_err(se), .ovf_err(oe), .err_clr(clr), .word_cnt(wc)
  );

  codeword_deserializer #(.WORD_W(W), .FIFO_DEPTH(D), .CONTINUOUS(0)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .ser_in(sin), .ser_valid(sv),
    .sof(sf), .out_word(ow0), .out_valid(ov0), .out_ready(rdy),
    .sync_err(se0), .ovf_err(oe0), .err_clr(clr), .word_cnt(wc0)
  );

  // One clock: drive inputs, advance the model (continuous mode), sample #1 after edge
  task automatic step(input bit r, input bit v, input bit b,
                      input bit s, input bit rd, input bit c);
    bit done, ss, so, pop, full;
    logic [W-1:0] w;
    done = 0; ss = 0; so = 0; w = '0;
    rst = r; sv = v; sin = b; sf = s; rdy = rd; clr = c;
    if (r) begin
      m_in = 0; m_bits.delete(); m_q.delete();
      m_last = '0; m_sync = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      pop  = (m_q.size() > 0) && rd;
      full = (m_q.size() == D);
      if (v) begin
        if (s) begin
          if (m_in && m_bits.size() != 0) ss = 1;
          m_bits.delete();
          m_bits.push_back(b);
          m_in = 1;
        end else if (m_in) begin
          m_bits.push_back(b);
        end
        if (m_bits.size() == W) begin
          for (int i = 0; i < W; i++) w[i] = m_bits[i];
          done = 1;
          m_bits.delete();
          m_in = 1;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (done) begin
        if (!full || pop) begin
          m_q.push_back(w);
          m_cnt = (m_cnt + 1) % 256;
        end else so = 1;
      end
      m_sync = (m_sync && !c) || ss;
      m_ovf  = (m_ovf && !c) || so;
      if (m_q.size() > 0) m_last = m_q[0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w, input bit sof1, input bit rd_body,
                      input bit rd_last, input bit c_last);
    for (int i = 0; i < W; i++)
      step(0, 1, w[i], sof1 && (i == 0), (i == W-1) ? rd_last : rd_body,
           (i == W-1) ? c_last : 1'b0);
  endtask

  task automatic idle(input bit rd);
    step(0, 0, 0, 0, rd, 0);
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    checks += 6;
    if (ov !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ov); end
    if (ow !== 7'h00) begin errors++; $display("FAIL rst_word got %h exp 00", ow); end
    if (se !== 1'b0) begin errors++; $display("FAIL rst_sync got %b exp 0", se); end
    if (oe !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", oe); end
    if (wc !== 8'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", wc); end
    if (ov0 !== 1'b0) begin errors++; $display("FAIL rst_valid0 got %b exp 0", ov0); end
  endtask

  task automatic test_single;
    bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 1, pat[i], i == 0, 1, 0);
      if (i < 6) begin
        checks++;
        if (ov !== 1'b0) begin errors++; $display("FAIL single_early bit %0d got %b exp 0", i, ov); end
      end
    end
    checks += 3;
    if (ov !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", ov); end
    if (ow !== 7'b1011001) begin errors++; $display("FAIL single_word got %h exp 59", ow); end
    if (wc !== 8'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", wc); end
    idle(1);
    checks += 2;
    if (ov !== 1'b0) begin errors++; $display("FAIL single_fall got %b exp 0", ov); end
    if (ow !== 7'h59) begin errors++; $display("FAIL single_hold got %h exp 59", ow); end
  endtask

  task automatic test_overflow;
    step(1, 0, 0, 0, 0, 0);
    send(7'h59, 1, 0, 0, 0);
    send(7'h2A, 1, 0, 0, 0);
    send(7'h7F, 1, 0, 0, 0);
    checks += 5;
    if (oe !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", oe); end
    if (wc !== 8'd2) begin errors++; $display("FAIL ovf_cnt got %0d exp 2", wc); end
    if (ow !== 7'h59) begin errors++; $display("FAIL ovf_head got %h exp 59", ow); end
    if (ov !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b exp 1", ov); end
    if (se !== 1'b0) begin errors++; $display("FAIL ovf_sync got %b exp 0", se); end
    idle(1);
    checks += 2;
    if (ow !== 7'h2A) begin errors++; $display("FAIL ovf_pop1 got %h exp 2a", ow); end
    if (ov !== 1'b1) begin errors++; $display("FAIL ovf_pop1v got %b exp 1", ov); end
    idle(1);
    checks += 2;
    if (ov !== 1'b0) begin errors++; $display("FAIL ovf_pop2v got %b exp 0", ov); end
    if (ow !== 7'h2A) begin errors++; $display("FAIL ovf_hold got %h exp 2a", ow); end
  endtask

  task automatic test_sync;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    send(7'b1000000, 1, 0, 0, 0);
    checks += 4;
    if (se !== 1'b1) begin errors++; $display("FAIL sync_flag got %b exp 1", se); end
    if (ow !== 7'h40) begin errors++; $display("FAIL sync_word got %h exp 40", ow); end
    if (ov !== 1'b1) begin errors++; $display("FAIL sync_valid got %b exp 1", ov); end
    if (wc !== 8'd1) begin errors++; $display("FAIL sync_cnt got %0d exp 1", wc); end
    idle(1);
    checks++;
    if (ov !== 1'b0) begin errors++; $display("FAIL sync_only1 got %b exp 0", ov); end
  endtask

  task automatic test_noncont;
    step(1, 0, 0, 0, 0, 0);
    send(7'h15, 1, 1, 1, 0);
    idle(1);
    send(7'h33, 0, 1, 1, 0);
    checks += 4;
    if (ov !== 1'b1) begin errors++; $display("FAIL cont_valid got %b exp 1", ov); end
    if (ow !== 7'h33) begin errors++; $display("FAIL cont_word got %h exp 33", ow); end
    if (ov0 !== 1'b0) begin errors++; $display("FAIL nc_valid got %b exp 0", ov0); end
    if (wc0 !== 8'd1) begin errors++; $display("FAIL nc_cnt got %0d exp 1", wc0); end
    idle(1);
    send(7'h0C, 1, 0, 0, 0);
    checks += 3;
    if (ow0 !== 7'h0C) begin errors++; $display("FAIL nc_word got %h exp 0c", ow0); end
    if (wc0 !== 8'd2) begin errors++; $display("FAIL nc_cnt2 got %0d exp 2", wc0); end
    if (wc !== 8'd3) begin errors++; $display("FAIL cont_cnt got %0d exp 3", wc); end
  endtask

  task automatic test_full_pop;
    step(1, 0, 0, 0, 0, 0);
    send(7'h11, 1, 0, 0, 0);
    send(7'h22, 1, 0, 0, 0);
    send(7'h33, 1, 0, 1, 0);
    checks += 4;
    if (oe !== 1'b0) begin errors++; $display("FAIL fp_ovf got %b exp 0", oe); end
    if (wc !== 8'd3) begin errors++; $display("FAIL fp_cnt got %0d exp 3", wc); end
    if (ow !== 7'h22) begin errors++; $display("FAIL fp_head got %h exp 22", ow); end
    if (ov !== 1'b1) begin errors++; $display("FAIL fp_valid got %b exp 1", ov); end
    send(7'h44, 1, 0, 0, 1);
    checks += 2;
    if (oe !== 1'b1) begin errors++; $display("FAIL clr_race got %b exp 1", oe); end
    if (wc !== 8'd3) begin errors++; $display("FAIL clr_cnt got %0d exp 3", wc); end
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if (oe !== 1'b0) begin errors++; $display("FAIL clr got %b exp 0", oe); end
    idle(1);
    checks += 2;
    if (ow !== 7'h33) begin errors++; $display("FAIL fp_pop1 got %h exp 33", ow); end
    if (ov !== 1'b1) begin errors++; $display("FAIL fp_pop1v got %b exp 1", ov); end
    idle(1);
    checks++;
    if (ov !== 1'b0) begin errors++; $display("FAIL fp_empty got %b exp 0", ov); end
  endtask

  task automatic test_reset_mid;
    step(1, 0, 0, 0, 0, 0);
    send(7'h11, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, i[0], i == 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    checks += 5;
    if (ov !== 1'b0) begin errors++; $display("FAIL rm_valid got %b exp 0", ov); end
    if (wc !== 8'd0) begin errors++; $display("FAIL rm_cnt got %0d exp 0", wc); end
    if (se !== 1'b0) begin errors++; $display("FAIL rm_sync got %b exp 0", se); end
    if (oe !== 1'b0) begin errors++; $display("FAIL rm_ovf got %b exp 0", oe); end
    if (ow !== 7'h00) begin errors++; $display("FAIL rm_word got %h exp 00", ow); end
    send(7'h6E, 1, 0, 0, 0);
    checks += 3;
    if (ow !== 7'h6E) begin errors++; $display("FAIL rm_fresh got %h exp 6e", ow); end
    if (ov !== 1'b1) begin errors++; $display("FAIL rm_fvalid got %b exp 1", ov); end
    if (wc !== 8'd1) begin errors++; $display("FAIL rm_fcnt got %0d exp 1", wc); end
  endtask

  task automatic test_random;
    bit r, v, b, s, rd, c;
    step(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 499) == 0);
      v  = ($urandom_range(0, 9) < 7);
      b  = $urandom_range(0, 1);
      s  = ($urandom_range(0, 9) == 0);
      rd = ($urandom_range(0, 9) < 4);
      c  = ($urandom_range(0, 19) == 0);
      step(r, v, b, s, rd, c);
      checks += 5;
      if (ov !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", n, ov, m_q.size() > 0); end
      if (ow !== m_last) begin errors++; $display("FAIL rnd_word cyc %0d got %h exp %h", n, ow, m_last); end
      if (se !== m_sync) begin errors++; $display("FAIL rnd_sync cyc %0d got %b exp %b", n, se, m_sync); end
      if (oe !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc %0d got %b exp %b", n, oe, m_ovf); end
      if (wc !== 8'(m_cnt)) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", n, wc, m_cnt); end
    end
  endtask

  initial begin
    rst = 1; sv = 0; sin = 0; sf = 0; rdy = 0; clr = 0;
    test_reset();
    test_single();
    test_overflow();
    test_sync();
    test_noncont();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
